icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 157 +++++++++++++++
 tb/tb_icache.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache: LINES lines of four 32-bit words, single outstanding fetch,
// critical-line refill in word order 0..3 from a simple req/valid memory port.
//   state   | meaning
//   IDLE    | apply pending flush, accept next fetch
//   LOOKUP  | tag compare on registered address
//   REFILL  | fetch four words of the missed line
//   RESPOND | return requested word from refilled line
module icache #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_ena,
  input  logic [31:0] icache_addr,
  output logic        icache_valid,
  output logic [31:0] icache_data,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    REFILL  = 2'd2,
    RESPOND = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [29:0]      addr_q, addr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic             flush_pend_q, flush_pend_d;
  logic             icache_valid_q, icache_valid_d;
  logic [31:0]      icache_data_q, icache_data_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;

  logic [31:0]      data_mem [LINES*4];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic             data_we, tag_we;

  logic [1:0]       req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             unused_addr_bits;

  // addr_q holds the word address, so byte-offset bits never enter the cache
  assign req_off = addr_q[1:0];
  assign req_idx = addr_q[IDX_W+1:2];
  assign req_tag = addr_q[29:IDX_W+2];
  assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_addr_bits = ^icache_addr[1:0];

  assign icache_valid = icache_valid_q;
  assign icache_data  = icache_data_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    valid_d        = valid_q;
    flush_pend_d   = flush_pend_q;
    icache_valid_d = 1'b0;
    icache_data_d  = '0;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    data_we        = 1'b0;
    tag_we         = 1'b0;

    if (flush && state_q != IDLE) flush_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (flush || flush_pend_q) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        // the core still holds ena during the response cycle; do not re-accept it
        end else if (icache_ena && !icache_valid_q) begin
          addr_d  = icache_addr[31:2];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          icache_valid_d = 1'b1;
          icache_data_d  = data_mem[{req_idx, req_off}];
          state_d        = IDLE;
        end else begin
          cnt_d      = 2'd0;
          mem_req_d  = 1'b1;
          mem_addr_d = {addr_q[29:2], 2'b00, 2'b00};
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (mem_valid && mem_req_q) begin
          data_we = 1'b1;
          if (cnt_q == 2'd3) begin
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
            mem_req_d        = 1'b0;
            cnt_d            = 2'd0;
            state_d          = RESPOND;
          end else begin
            cnt_d      = cnt_q + 2'd1;
            mem_addr_d = {addr_q[29:2], cnt_q + 2'd1, 2'b00};
          end
        end
      end
      RESPOND: begin
        icache_valid_d = 1'b1;
        icache_data_d  = data_mem[{req_idx, req_off}];
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      cnt_q          <= '0;
      valid_q        <= '0;
      flush_pend_q   <= 1'b0;
      icache_valid_q <= 1'b0;
      icache_data_q  <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      valid_q        <= valid_d;
      flush_pend_q   <= flush_pend_d;
      icache_valid_q <= icache_valid_d;
      icache_data_q  <= icache_data_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we && !rst) data_mem[{req_idx, cnt_q}] <= mem_data;
    if (tag_we && !rst)  tag_mem[req_idx] <= req_tag;
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: scoreboard of expected fetch data and refill addresses,
// reactive memory model with optional random latency and spurious mem_valid injection.
module tb_icache;
  logic        clk;
  logic        rst;
  logic        icache_ena;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_data;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  icache #(.LINES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .icache_ena   (icache_ena),
    .icache_addr  (icache_addr),
    .icache_valid (icache_valid),
    .icache_data  (icache_data),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          beats = 0;
  int          max_delay = 0;
  bit          spurious = 1'b0;
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_maddr_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // memory model: answers each requested word after 0..max_delay cycles
  initial begin
    bit          have;
    int          wait_cnt;
    logic [31:0] held;
    have = 1'b0; wait_cnt = 0; held = '0;
    mem_valid = 1'b0; mem_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_valid = 1'b0;
      mem_data  = '0;
      if (rst || !mem_req) begin
        have = 1'b0;
        if (spurious && !rst) begin
          mem_valid = 1'b1;
          mem_data  = 32'hDEAD_BEEF;
        end
      end else begin
        if (!have) begin
          have     = 1'b1;
          held     = mem_addr;
          wait_cnt = int'($urandom_range(max_delay, 0));
        end else begin
          chk("mem_addr_stable", mem_addr, held);
        end
        if (wait_cnt == 0) begin
          beats++;
          if (exp_maddr_q.size() == 0) chk("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
          else chk("refill_addr", mem_addr, exp_maddr_q.pop_front());
          mem_valid = 1'b1;
          mem_data  = mem_word(mem_addr);
          have      = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input bit miss, input int flush_beat);
    int cyc;
    int b0;
    bit got;
    bit fl_done;
    exp_data_q.push_back(mem_word(a));
    if (miss) for (int i = 0; i < 4; i++) exp_maddr_q.push_back({a[31:4], 4'b0} + 32'(i * 4));
    b0 = beats; got = 1'b0; fl_done = 1'b0; cyc = 0;
    @(negedge clk);
    icache_ena  = 1'b1;
    icache_addr = a;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      if (icache_valid) begin
        got = 1'b1;
        chk("resp_data", icache_data, exp_data_q.pop_front());
        if (!miss) chk("hit_latency", cyc, 2);
      end else if (flush_beat >= 0 && !fl_done && (beats - b0) >= flush_beat) begin
        flush   = 1'b1;
        fl_done = 1'b1;
      end
    end
    flush      = 1'b0;
    icache_ena = 1'b0;
    if (!got) begin
      chk("fetch_timeout", 32'd0, 32'd1);
      if (exp_data_q.size() > 0) void'(exp_data_q.pop_front());
      exp_maddr_q.delete();
    end
    @(negedge clk);
    chk("single_pulse", {31'd0, icache_valid}, 32'd0);
    chk("idle_data_zero", icache_data, 32'd0);
    chk("refill_words_left", exp_maddr_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int b0;
    rst = 1'b1; icache_ena = 1'b0; icache_addr = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_icache_valid", {31'd0, icache_valid}, 32'd0);
    chk("rst_icache_data", icache_data, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // cold miss, hits in same line, conflict on index 0
    fetch(32'h0000_0108, 1'b1, -1);
    fetch(32'h0000_010C, 1'b0, -1);
    fetch(32'h0000_0100, 1'b0, -1);
    fetch(32'h0000_0200, 1'b1, -1);
    fetch(32'h0000_0100, 1'b1, -1);
    fetch(32'h0000_0104, 1'b0, -1);

    // flush in IDLE
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    fetch(32'h0000_0100, 1'b1, -1);

    // flush mid-refill, then flush coinciding with the last refill word
    fetch(32'h0000_0140, 1'b1, 2);
    fetch(32'h0000_0144, 1'b1, -1);
    fetch(32'h0000_0188, 1'b1, 4);
    fetch(32'h0000_0184, 1'b1, -1);

    // mem_valid with no request must not disturb the cache
    spurious = 1'b1;
    repeat (4) @(negedge clk);
    spurious = 1'b0;
    fetch(32'h0000_018C, 1'b0, -1);

    // reset after the second refill word
    exp_maddr_q.push_back(32'h0000_0300);
    exp_maddr_q.push_back(32'h0000_0304);
    b0 = beats; cyc = 0;
    @(negedge clk);
    icache_ena = 1'b1; icache_addr = 32'h0000_0308;
    while ((beats - b0) < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("beats_before_rst", beats - b0, 32'd2);
    rst = 1'b1; icache_ena = 1'b0;
    @(negedge clk);
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_icache_valid", {31'd0, icache_valid}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    fetch(32'h0000_0308, 1'b1, -1);
    fetch(32'h0000_0300, 1'b0, -1);

    // slow memory with random per-word latency
    max_delay = 5;
    fetch(32'h0000_0404, 1'b1, -1);
    fetch(32'h0000_051C, 1'b1, -1);
    fetch(32'h0000_0624, 1'b1, -1);
    fetch(32'h0000_0400, 1'b0, -1);
    fetch(32'h0000_0518, 1'b0, -1);
    fetch(32'h0000_0628, 1'b0, -1);

    chk("data_queue_empty", exp_data_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
